// File: rtl/horizontal_in_process.sv
// Horizontal input processor: replays the 16-cycle horizontal schedule from ROM banks 0/1/2
// and streams the returned words as operands to horizontal multipliers 0 and 1.
module horizontal_in_process #(
  parameter int unsigned P_WIDTH    = 64,
  parameter int unsigned GRP_WIDTH  = 4,
  parameter int unsigned NUM_GROUPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 horizontal_start,
  input  logic                 horizontal_en_in,
  input  logic [P_WIDTH-1:0]   rom0_rdata,
  input  logic [P_WIDTH-1:0]   rom1_rdata,
  input  logic [P_WIDTH-1:0]   rom2_rdata,
  output logic                 rom0_re,
  output logic                 rom1_re,
  output logic                 rom2_re,
  output logic [GRP_WIDTH+1:0] rom0_addr,
  output logic [GRP_WIDTH+2:0] rom1_addr,
  output logic [GRP_WIDTH+2:0] rom2_addr,
  output logic [P_WIDTH-1:0]   horizontal_mul0_out,
  output logic [P_WIDTH-1:0]   horizontal_mul1_out,
  output logic                 mul0_valid,
  output logic                 mul1_valid,
  output logic                 horizontal_done,
  output logic                 busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(15);
  localparam logic [GRP_WIDTH-1:0] GRP_LAST = GRP_WIDTH'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_ROM0 = 2'd0,
    SRC_ROM1 = 2'd1,
    SRC_ROM2 = 2'd2
  } src_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [GRP_WIDTH-1:0] grp;
  logic                 drain;

  src_t                 sel_d1;
  logic                 m1_d1;
  logic                 vld_d1;
  logic                 last_d1;

  logic                 run;
  logic                 ph_lo;
  logic                 ph_mid;
  logic                 ph_hi;
  logic                 last_beat;
  logic                 abort;
  src_t                 sel_nxt;
  logic [P_WIDTH-1:0]   mul0_src;

  // Schedule phase: 0-3 ROM0 (+ROM2 upper half to mul1), 4-11 ROM1, 12-15 ROM2 lower half
  assign run       = (state == S_RUN);
  assign ph_lo     = (cnt[3:2] == 2'b00);
  assign ph_hi     = (cnt[3:2] == 2'b11);
  assign ph_mid    = !ph_lo && !ph_hi;
  assign last_beat = (cnt == CNT_LAST) && (grp == GRP_LAST);
  assign abort     = (state != S_IDLE) && !horizontal_en_in;
  assign busy      = (state != S_IDLE);

  always_comb begin
    rom0_re   = 1'b0;
    rom1_re   = 1'b0;
    rom2_re   = 1'b0;
    rom0_addr = '0;
    rom1_addr = '0;
    rom2_addr = '0;
    if (run) begin
      rom0_re = ph_lo;
      rom1_re = ph_mid;
      rom2_re = ph_lo || ph_hi;
      if (ph_lo) begin
        rom0_addr = {grp, cnt[1:0]};
      end
      if (ph_mid) begin
        rom1_addr = {grp, 3'(cnt - CNT_W'(4))};
      end
      if (ph_lo || ph_hi) begin
        rom2_addr = {grp, ph_lo, cnt[1:0]};
      end
    end
  end

  always_comb begin
    sel_nxt = SRC_ROM2;
    if (ph_lo) begin
      sel_nxt = SRC_ROM0;
    end else if (ph_mid) begin
      sel_nxt = SRC_ROM1;
    end
  end

  always_comb begin
    mul0_src = rom0_rdata;
    case (sel_d1)
      SRC_ROM1: mul0_src = rom1_rdata;
      SRC_ROM2: mul0_src = rom2_rdata;
      default:  mul0_src = rom0_rdata;
    endcase
  end

  // Control FSM plus the two pipeline stages that track the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      grp                 <= '0;
      drain               <= 1'b0;
      sel_d1              <= SRC_ROM0;
      m1_d1               <= 1'b0;
      vld_d1              <= 1'b0;
      last_d1             <= 1'b0;
      horizontal_mul0_out <= '0;
      horizontal_mul1_out <= '0;
      mul0_valid          <= 1'b0;
      mul1_valid          <= 1'b0;
      horizontal_done     <= 1'b0;
    end else if (abort) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      grp                 <= '0;
      drain               <= 1'b0;
      sel_d1              <= SRC_ROM0;
      m1_d1               <= 1'b0;
      vld_d1              <= 1'b0;
      last_d1             <= 1'b0;
      horizontal_mul0_out <= '0;
      horizontal_mul1_out <= '0;
      mul0_valid          <= 1'b0;
      mul1_valid          <= 1'b0;
      horizontal_done     <= 1'b0;
    end else begin
      sel_d1  <= run ? sel_nxt : SRC_ROM0;
      m1_d1   <= run && ph_lo;
      vld_d1  <= run;
      last_d1 <= run && last_beat;

      horizontal_mul0_out <= vld_d1 ? mul0_src : '0;
      horizontal_mul1_out <= m1_d1 ? rom2_rdata : '0;
      mul0_valid          <= vld_d1;
      mul1_valid          <= m1_d1;
      horizontal_done     <= last_d1;

      case (state)
        S_IDLE: begin
          if (horizontal_start && horizontal_en_in) begin
            state <= S_RUN;
            cnt   <= '0;
            grp   <= '0;
          end
        end
        S_RUN: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (grp == GRP_LAST) begin
              state <= S_DRAIN;
              grp   <= '0;
              drain <= 1'b0;
            end else begin
              grp <= GRP_WIDTH'(grp + 1'b1);
            end
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
          end
        end
        S_DRAIN: begin
          // Two cycles: one for the ROM return, one for the output register
          if (drain) begin
            state <= S_IDLE;
            drain <= 1'b0;
          end else begin
            drain <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          grp   <= '0;
          drain <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horizontal_in_process.sv
// Testbench for horizontal_in_process: two instances (2 groups and 1 group) fed by ROM models,
// checked cycle by cycle against an expected operand stream built from the schedule rules.
module tb_horizontal_in_process;

  localparam int unsigned PW = 64;
  localparam int unsigned GW = 4;

  typedef struct packed {
    logic          re0;
    logic          re1;
    logic          re2;
    logic [6:0]    a0;
    logic [6:0]    a1;
    logic [6:0]    a2;
    logic          m0v;
    logic          m1v;
    logic          done;
    logic          busy;
    logic [PW-1:0] m0;
    logic [PW-1:0] m1;
  } obs_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i [2];
  logic        en_i    [2];
  logic [31:0] salt    = '0;
  int          errors  = 0;
  int          checks  = 0;

  logic [PW-1:0] r0a = '0, r1a = '0, r2a = '0;
  logic          re0a, re1a, re2a, v0a, v1a, dna, bsa;
  logic [GW+1:0] a0a;
  logic [GW+2:0] a1a, a2a;
  logic [PW-1:0] m0a, m1a;

  logic [PW-1:0] r0b = '0, r1b = '0, r2b = '0;
  logic          re0b, re1b, re2b, v0b, v1b, dnb, bsb;
  logic [GW+1:0] a0b;
  logic [GW+2:0] a1b, a2b;
  logic [PW-1:0] m0b, m1b;

  always #5 clk = ~clk;

  horizontal_in_process #(.P_WIDTH(PW), .GRP_WIDTH(GW), .NUM_GROUPS(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .horizontal_start(start_i[0]), .horizontal_en_in(en_i[0]),
    .rom0_rdata(r0a), .rom1_rdata(r1a), .rom2_rdata(r2a),
    .rom0_re(re0a), .rom1_re(re1a), .rom2_re(re2a),
    .rom0_addr(a0a), .rom1_addr(a1a), .rom2_addr(a2a),
    .horizontal_mul0_out(m0a), .horizontal_mul1_out(m1a),
    .mul0_valid(v0a), .mul1_valid(v1a), .horizontal_done(dna), .busy(bsa)
  );

  horizontal_in_process #(.P_WIDTH(PW), .GRP_WIDTH(GW), .NUM_GROUPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .horizontal_start(start_i[1]), .horizontal_en_in(en_i[1]),
    .rom0_rdata(r0b), .rom1_rdata(r1b), .rom2_rdata(r2b),
    .rom0_re(re0b), .rom1_re(re1b), .rom2_re(re2b),
    .rom0_addr(a0b), .rom1_addr(a1b), .rom2_addr(a2b),
    .horizontal_mul0_out(m0b), .horizontal_mul1_out(m1b),
    .mul0_valid(v0b), .mul1_valid(v1b), .horizontal_done(dnb), .busy(bsb)
  );

  // ROM content: random salt, bank id and address, so every word is traceable
  function automatic logic [PW-1:0] word(input int id, input int addr);
    return {salt, 16'h0000, 8'(id), 8'(addr)};
  endfunction

  always @(posedge clk) begin
    if (re0a) r0a <= word(0, int'(a0a));
    if (re1a) r1a <= word(1, int'(a1a));
    if (re2a) r2a <= word(2, int'(a2a));
    if (re0b) r0b <= word(0, int'(a0b));
    if (re1b) r1b <= word(1, int'(a1b));
    if (re2b) r2b <= word(2, int'(a2b));
  end

  function automatic obs_t observe(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.re0 = re0a; o.re1 = re1a; o.re2 = re2a;
      o.a0 = 7'(a0a); o.a1 = 7'(a1a); o.a2 = 7'(a2a);
      o.m0v = v0a; o.m1v = v1a; o.done = dna; o.busy = bsa;
      o.m0 = m0a; o.m1 = m1a;
    end else begin
      o.re0 = re0b; o.re1 = re1b; o.re2 = re2b;
      o.a0 = 7'(a0b); o.a1 = 7'(a1b); o.a2 = 7'(a2b);
      o.m0v = v0b; o.m1v = v1b; o.done = dnb; o.busy = bsb;
      o.m0 = m0b; o.m1 = m1b;
    end
    return o;
  endfunction

  // One run on instance inst; abort_t>0 drops en_in after sampling cycle abort_t
  task automatic run_stream(input int inst, input int ng, input int abort_t, input bit ign);
    logic [PW-1:0] q0[$];
    logic [PW-1:0] q1[$];
    obs_t o;
    int k, tend, g, c, kc, ea0, ea1, ea2;
    bit ev0, ev1, edn, ebs, rn, er0, er1, er2;
    logic [PW-1:0] e0, e1;
    for (int gi = 0; gi < ng; gi++) begin
      for (int i = 0; i < 4; i++) begin
        q0.push_back(word(0, gi*4 + i));
        q1.push_back(word(2, gi*8 + 4 + i));
      end
      for (int i = 0; i < 8; i++) begin
        q0.push_back(word(1, gi*8 + i));
        q1.push_back('0);
      end
      for (int i = 0; i < 4; i++) begin
        q0.push_back(word(2, gi*8 + i));
        q1.push_back('0);
      end
    end
    tend = (abort_t > 0) ? abort_t : 16*ng + 2;
    en_i[inst]    = 1'b1;
    start_i[inst] = 1'b1;
    @(posedge clk); #1;
    start_i[inst] = 1'b0;
    for (int t = 0; t <= tend; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      o   = observe(inst);
      k   = t - 2;
      ev0 = (k >= 0) && (k < 16*ng);
      kc  = ev0 ? (k % 16) : 0;
      ev1 = ev0 && (kc < 4);
      e0  = ev0 ? q0[k] : '0;
      e1  = ev0 ? q1[k] : '0;
      edn = (k == 16*ng - 1);
      ebs = (t <= 16*ng + 1);
      rn  = (t < 16*ng);
      c   = t % 16;
      g   = t / 16;
      er0 = rn && (c < 4);
      er1 = rn && (c >= 4) && (c < 12);
      er2 = rn && ((c < 4) || (c >= 12));
      ea0 = er0 ? g*4 + c : 0;
      ea1 = er1 ? g*8 + c - 4 : 0;
      ea2 = er2 ? g*8 + ((c < 4) ? 4 : 0) + (c % 4) : 0;

      checks++;
      if (o.m0v !== ev0) begin
        errors++; $display("FAIL mul0_valid inst=%0d t=%0d got=%b exp=%b", inst, t, o.m0v, ev0);
      end
      checks++;
      if (o.m0 !== e0) begin
        errors++; $display("FAIL mul0_out inst=%0d t=%0d got=%h exp=%h", inst, t, o.m0, e0);
      end
      checks++;
      if (o.m1v !== ev1) begin
        errors++; $display("FAIL mul1_valid inst=%0d t=%0d got=%b exp=%b", inst, t, o.m1v, ev1);
      end
      checks++;
      if (o.m1 !== e1) begin
        errors++; $display("FAIL mul1_out inst=%0d t=%0d got=%h exp=%h", inst, t, o.m1, e1);
      end
      checks++;
      if (o.done !== edn) begin
        errors++; $display("FAIL done inst=%0d t=%0d got=%b exp=%b", inst, t, o.done, edn);
      end
      checks++;
      if (o.busy !== ebs) begin
        errors++; $display("FAIL busy inst=%0d t=%0d got=%b exp=%b", inst, t, o.busy, ebs);
      end
      checks++;
      if ({o.re0, o.re1, o.re2} !== {er0, er1, er2}) begin
        errors++; $display("FAIL rom_re inst=%0d t=%0d got=%b exp=%b", inst, t,
                           {o.re0, o.re1, o.re2}, {er0, er1, er2});
      end
      if (er0 || !rn) begin
        checks++;
        if (o.a0 !== 7'(ea0)) begin
          errors++; $display("FAIL rom0_addr inst=%0d t=%0d got=%h exp=%h", inst, t, o.a0, 7'(ea0));
        end
      end
      if (er1 || !rn) begin
        checks++;
        if (o.a1 !== 7'(ea1)) begin
          errors++; $display("FAIL rom1_addr inst=%0d t=%0d got=%h exp=%h", inst, t, o.a1, 7'(ea1));
        end
      end
      if (er2 || !rn) begin
        checks++;
        if (o.a2 !== 7'(ea2)) begin
          errors++; $display("FAIL rom2_addr inst=%0d t=%0d got=%h exp=%h", inst, t, o.a2, 7'(ea2));
        end
      end
      if (inst == 0 && t == 25) begin
        checks++;
        if ({o.re1, o.a1} !== {1'b1, 7'b0001101}) begin
          errors++; $display("FAIL addr_g1_c9 got=%b/%b exp=1/0001101", o.re1, o.a1);
        end
      end
      start_i[inst] = ign && (t == 5 || t == 12);
    end
    if (abort_t > 0) begin
      start_i[inst] = 1'b0;
      en_i[inst]    = 1'b0;
      @(posedge clk); #1;
      o = observe(inst);
      checks++;
      if ({o.m0v, o.m1v, o.m0, o.m1} !== '0) begin
        errors++; $display("FAIL abort_outputs inst=%0d got v=%b%b m0=%h m1=%h exp=0",
                           inst, o.m0v, o.m1v, o.m0, o.m1);
      end
      checks++;
      if ({o.busy, o.done, o.re0, o.re1, o.re2} !== 5'b0) begin
        errors++; $display("FAIL abort_ctrl inst=%0d got busy=%b done=%b re=%b%b%b exp=0",
                           inst, o.busy, o.done, o.re0, o.re1, o.re2);
      end
      en_i[inst] = 1'b1;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      o = observe(i);
      checks++;
      if (o !== '0) begin
        errors++; $display("FAIL reset_state inst=%0d got=%h exp=0", i, o);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    salt = $urandom;
    run_stream(0, 2, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    salt = $urandom;
    run_stream(0, 2, 0, 1'b1);
  endtask

  task automatic test_abort();
    salt = $urandom;
    run_stream(0, 2, 10, 1'b0);
    run_stream(0, 2, 0, 1'b0);
    run_stream(0, 2, 32, 1'b0);
    run_stream(0, 2, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      salt = $urandom;
      run_stream(0, 2, int'($urandom_range(1, 32)), 1'(($urandom_range(0, 1))));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_stream(0, 2, 0, 1'b0);
    end
  endtask

  task automatic test_start_no_en();
    obs_t o;
    start_i[0] = 1'b1;
    en_i[0]    = 1'b0;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    en_i[0]    = 1'b1;
    o = observe(0);
    checks++;
    if ({o.busy, o.re0, o.re2} !== 3'b0) begin
      errors++; $display("FAIL start_no_en got busy=%b re0=%b re2=%b exp=0", o.busy, o.re0, o.re2);
    end
    @(posedge clk); @(posedge clk); #1;
    o = observe(0);
    checks++;
    if (o.m0v !== 1'b0) begin
      errors++; $display("FAIL start_no_en_valid got=%b exp=0", o.m0v);
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    salt = $urandom;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    o = observe(0);
    checks++;
    if ({o.m0v, o.busy} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_run got v=%b busy=%b exp=1/1", o.m0v, o.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = observe(0);
    checks++;
    if (o !== '0) begin
      errors++; $display("FAIL async_reset got=%h exp=0", o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_stream(0, 2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    run_stream(1, 1, 0, 1'b0);
    run_stream(1, 1, 0, 1'b0);
    salt = $urandom;
    run_stream(1, 1, 0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    start_i[0] = 1'b0; start_i[1] = 1'b0;
    en_i[0]    = 1'b1; en_i[1]    = 1'b1;
    test_reset();
    test_stream();
    test_start_ignored();
    test_abort();
    test_start_no_en();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
